// File: rtl/bullet.sv
// Single player bullet: spawns above the paddle on a frame strobe after a fire
// request, climbs BULLET_SPEED pixels per frame, and draws itself into a pixel layer.
module bullet #(
  parameter int          HRES         = 1280,
  parameter int          VRES         = 720,
  parameter int          PADDLE_W     = 64,
  parameter int          PADDLE_H     = 16,
  parameter int          BULLET_W     = 4,
  parameter int          BULLET_H     = 16,
  parameter int          BULLET_SPEED = 8,
  parameter logic [23:0] BULLET_COLOR = {8'hFF, 8'hFF, 8'hFF}
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic               fire,
  input  logic signed [11:0] player_x,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  output logic        [7:0]  pixel [0:2],
  output logic               bullet_active,
  output logic signed [11:0] bullet_left,
  output logic signed [11:0] bullet_right,
  output logic signed [11:0] bullet_top,
  output logic signed [11:0] bullet_bottom
);

  localparam logic signed [12:0] X_OFFSET  = 13'(PADDLE_W / 2 - BULLET_W / 2);
  localparam logic signed [12:0] X_MAX     = 13'(HRES - BULLET_W);
  localparam logic signed [11:0] SPAWN_TOP = 12'(VRES - PADDLE_H - BULLET_H);
  localparam logic signed [11:0] W_M1      = 12'(BULLET_W - 1);
  localparam logic signed [11:0] H_M1      = 12'(BULLET_H - 1);
  localparam logic signed [11:0] SPEED     = 12'(BULLET_SPEED);

  logic               pending;
  logic signed [12:0] centred;
  logic signed [11:0] spawn_left;
  logic signed [11:0] moved_top;
  logic               spawn;
  logic               in_box;

  // Centre on the paddle with one extra bit so the clamp sees true overflow.
  always_comb begin
    centred = {player_x[11], player_x} + X_OFFSET;
    if (centred < 13'sd0)
      spawn_left = 12'sd0;
    else if (centred > X_MAX)
      spawn_left = X_MAX[11:0];
    else
      spawn_left = centred[11:0];
  end

  always_comb begin
    moved_top = bullet_top - SPEED;
    spawn     = fsync && !bullet_active && (pending || fire);
    in_box    = bullet_active &&
                (hpos >= bullet_left) && (hpos <= bullet_right) &&
                (vpos >= bullet_top)  && (vpos <= bullet_bottom);
  end

  // Spawn takes priority over motion; fire while in flight is simply dropped.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      bullet_active <= 1'b0;
      pending       <= 1'b0;
      bullet_left   <= '0;
      bullet_right  <= '0;
      bullet_top    <= '0;
      bullet_bottom <= '0;
      for (int i = 0; i < 3; i++) pixel[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 3; i++)
        pixel[i] <= in_box ? BULLET_COLOR[23 - 8 * i -: 8] : 8'h00;
      if (spawn) begin
        bullet_active <= 1'b1;
        pending       <= 1'b0;
        bullet_left   <= spawn_left;
        bullet_right  <= spawn_left + W_M1;
        bullet_top    <= SPAWN_TOP;
        bullet_bottom <= SPAWN_TOP + H_M1;
      end else if (fsync && bullet_active) begin
        if (moved_top < 12'sd0) begin
          bullet_active <= 1'b0;
        end else begin
          bullet_top    <= moved_top;
          bullet_bottom <= moved_top + H_M1;
        end
      end else if (fire && !bullet_active) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bullet.sv
// Bench for bullet: directed scenarios followed by random frames, all outputs
// compared every cycle against a frame-level behavioural model.
module tb_bullet;

  localparam int HRES = 1280, VRES = 720, PADDLE_W = 64, PADDLE_H = 16;
  localparam int BULLET_W = 4, BULLET_H = 16, BULLET_SPEED = 8;
  localparam int COLOR = 32'h00FFFFFF;

  logic               clk;
  logic               rst, fsync, fire;
  logic signed [11:0] player_x, hpos, vpos;
  logic        [7:0]  pixel [0:2];
  logic               bullet_active;
  logic signed [11:0] bullet_left, bullet_right, bullet_top, bullet_bottom;

  int vectors = 0;
  int miscompares = 0;

  int m_active, m_pending, m_left, m_right, m_top, m_bottom, m_pix;

  bullet dut (
    .pixel_clk    (clk),
    .rst          (rst),
    .fsync        (fsync),
    .fire         (fire),
    .player_x     (player_x),
    .hpos         (hpos),
    .vpos         (vpos),
    .pixel        (pixel),
    .bullet_active(bullet_active),
    .bullet_left  (bullet_left),
    .bullet_right (bullet_right),
    .bullet_top   (bullet_top),
    .bullet_bottom(bullet_bottom)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Frame-level behaviour: a bullet either appears, climbs, or leaves the screen.
  task automatic modelStep(input logic r, input logic fs, input logic fi,
                           input int px, input int hp, input int vp);
    int c;
    if (r) begin
      m_active = 0; m_pending = 0; m_pix = 0;
      m_left = 0; m_right = 0; m_top = 0; m_bottom = 0;
      return;
    end
    m_pix = (m_active != 0 && hp >= m_left && hp < m_left + BULLET_W &&
             vp >= m_top && vp < m_top + BULLET_H) ? COLOR : 0;
    if (fs && m_active == 0 && (m_pending != 0 || fi)) begin
      c = px + PADDLE_W / 2 - BULLET_W / 2;
      if (c < 0) c = 0;
      if (c > HRES - BULLET_W) c = HRES - BULLET_W;
      m_left = c; m_right = c + BULLET_W - 1;
      m_top = VRES - PADDLE_H - BULLET_H; m_bottom = m_top + BULLET_H - 1;
      m_active = 1; m_pending = 0;
    end else if (fs && m_active != 0) begin
      if (m_top - BULLET_SPEED < 0) m_active = 0;
      else begin
        m_top = m_top - BULLET_SPEED; m_bottom = m_top + BULLET_H - 1;
      end
    end else if (fi && m_active == 0) begin
      m_pending = 1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic fs, input logic fi,
                               input int px, input int hp, input int vp);
    @(negedge clk);
    rst = r; fsync = fs; fire = fi;
    player_x = 12'(px); hpos = 12'(hp); vpos = 12'(vp);
    @(posedge clk);
    modelStep(r, fs, fi, px, hp, vp);
    #1;
    checkOutput("active", int'(bullet_active), m_active);
    checkOutput("left",   int'(bullet_left),   m_left);
    checkOutput("right",  int'(bullet_right),  m_right);
    checkOutput("top",    int'(bullet_top),    m_top);
    checkOutput("bottom", int'(bullet_bottom), m_bottom);
    checkOutput("pixel",  int'({pixel[0], pixel[1], pixel[2]}), m_pix);
  endtask

  initial begin
    int px, hp, vp;
    logic r, fs, fi;
    rst = 1'b1; fsync = 1'b0; fire = 1'b0;
    player_x = '0; hpos = '0; vpos = '0;
    m_active = 0; m_pending = 0; m_pix = 0;
    m_left = 0; m_right = 0; m_top = 0; m_bottom = 0;

    applyStimulus(1, 1, 1, 100, 0, 0);
    applyStimulus(1, 0, 0, 100, 0, 0);
    checkOutput("reset_active", int'(bullet_active), 0);
    checkOutput("reset_right",  int'(bullet_right), 0);

    // First shot from player_x=100.
    applyStimulus(0, 0, 1, 100, 0, 0);
    applyStimulus(0, 0, 1, 100, 0, 0);
    applyStimulus(0, 1, 0, 100, 0, 0);
    checkOutput("spawn_active", int'(bullet_active), 1);
    checkOutput("spawn_left",   int'(bullet_left),   130);
    checkOutput("spawn_right",  int'(bullet_right),  133);
    checkOutput("spawn_top",    int'(bullet_top),    688);
    checkOutput("spawn_bottom", int'(bullet_bottom), 703);

    applyStimulus(0, 0, 0, 500, 131, 690);
    checkOutput("pix_inside", int'({pixel[0], pixel[1], pixel[2]}), 32'hFFFFFF);
    applyStimulus(0, 0, 0, 500, 134, 690);
    checkOutput("pix_outside", int'({pixel[0], pixel[1], pixel[2]}), 0);

    // Full climb with a stray fire mid-flight that must be dropped.
    for (int i = 0; i < 86; i++) begin
      applyStimulus(0, 1, 0, 500, 0, 0);
      applyStimulus(0, 0, (i == 40), 500, 0, 0);
    end
    checkOutput("top_zero",      int'(bullet_top), 0);
    checkOutput("still_active",  int'(bullet_active), 1);
    checkOutput("x_held",        int'(bullet_left), 130);
    applyStimulus(0, 1, 0, 500, 0, 0);
    checkOutput("died_active", int'(bullet_active), 0);
    checkOutput("died_top",    int'(bullet_top), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 500, 0, 0);
    checkOutput("no_queued_fire", int'(bullet_active), 0);

    // Right-edge clamp, then a shot from near the left edge.
    applyStimulus(0, 0, 1, 1260, 0, 0);
    applyStimulus(0, 1, 0, 1260, 0, 0);
    checkOutput("clamp_left",  int'(bullet_left),  1276);
    checkOutput("clamp_right", int'(bullet_right), 1279);
    for (int i = 0; i < 87; i++) applyStimulus(0, 1, 0, 1260, 0, 0);
    checkOutput("clamp_died", int'(bullet_active), 0);
    applyStimulus(0, 0, 1, 20, 0, 0);
    applyStimulus(0, 1, 0, 20, 0, 0);
    checkOutput("left50", int'(bullet_left), 50);

    // Reset mid-flight with fire held across deassertion.
    applyStimulus(0, 0, 0, 20, 51, 690);
    checkOutput("pix_before_rst", int'({pixel[0], pixel[1], pixel[2]}), 32'hFFFFFF);
    applyStimulus(1, 1, 1, 20, 51, 690);
    checkOutput("rst_active", int'(bullet_active), 0);
    checkOutput("rst_left",   int'(bullet_left), 0);
    checkOutput("rst_top",    int'(bullet_top), 0);
    checkOutput("rst_pixel",  int'({pixel[0], pixel[1], pixel[2]}), 0);
    applyStimulus(1, 0, 1, 20, 0, 0);
    applyStimulus(0, 0, 1, 20, 0, 0);
    applyStimulus(0, 1, 0, 20, 0, 0);
    checkOutput("held_fire_spawn", int'(bullet_active), 1);

    // Random frames, raster often steered near the bullet to exercise pixel edges.
    for (int i = 0; i < 6000; i++) begin
      r  = ($urandom_range(0, 799) == 0);
      fs = ($urandom_range(0, 2) == 0);
      fi = ($urandom_range(0, 9) == 0);
      px = $urandom_range(0, 1500) - 100;
      if ($urandom_range(0, 1) == 0) begin
        hp = m_left + $urandom_range(0, 7) - 2;
        vp = m_top + $urandom_range(0, 19) - 2;
      end else begin
        hp = $urandom_range(0, 1400);
        vp = $urandom_range(0, 800);
      end
      applyStimulus(r, fs, fi, px, hp, vp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bullet.md
BULLET -- requirements
Module: bullet

Interface
REQ-001 Parameter HRES, default 1280, active screen width in pixels (from params package).
REQ-002 Parameter VRES, default 720, active screen height in pixels (from params package).
REQ-003 Parameter PADDLE_W, default 64, player paddle width; PADDLE_H, default 16, player paddle height.
REQ-004 Parameter BULLET_W, default 4; BULLET_H, default 16; bullet size in pixels.
REQ-005 Parameter BULLET_SPEED, default 8, upward pixels moved per frame.
REQ-006 Parameter BULLET_COLOR, default {8'hFF,8'hFF,8'hFF}, RGB of bullet pixels.
REQ-007 pixel_clk  in  1  sole clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 fsync  in  1  one-cycle frame-start strobe; motion updates only on it.
REQ-010 fire  in  1  fire request, level or pulse, any length.
REQ-011 player_x  in  12 signed  paddle left edge x.
REQ-012 hpos, vpos  in  12 signed each  current raster pixel coordinate.
REQ-013 pixel  out  3 x 8 (array [0:2])  [0]=R, [1]=G, [2]=B of bullet layer.
REQ-014 bullet_active  out  1  bullet in flight.
REQ-015 bullet_left, bullet_right, bullet_top, bullet_bottom  out  12 signed each  inclusive bullet bounding box.

Function
REQ-016 A pending-fire flag SHALL set on any cycle with fire=1 while bullet_active=0; fire while active SHALL be ignored and not queued.
REQ-017 On a cycle with fsync=1, bullet_active=0, and (pending flag or fire=1), the bullet SHALL spawn: bullet_active<=1, pending cleared.
REQ-018 Spawn left = player_x + PADDLE_W/2 - BULLET_W/2, clamped to [0, HRES-BULLET_W]; spawn top = VRES - PADDLE_H - BULLET_H.
REQ-019 bullet_right SHALL always equal bullet_left + BULLET_W - 1; bullet_bottom SHALL equal bullet_top + BULLET_H - 1.
REQ-020 On fsync with bullet_active=1: if bullet_top - BULLET_SPEED < 0 then bullet_active<=0 (position held), else bullet_top <= bullet_top - BULLET_SPEED; x unchanged during flight.
REQ-021 Spawn and move SHALL never occur on the same fsync; a spawn fsync does not also move.
REQ-022 When inactive, box outputs SHALL hold their last values; no motion without fsync.
REQ-023 Arithmetic SHALL be 12-bit signed; player_x changes after spawn SHALL not affect the bullet.
REQ-024 pixel SHALL be registered (1-cycle latency from hpos/vpos): BULLET_COLOR when bullet_active and left<=hpos<=right and top<=vpos<=bottom, else all zeros.
REQ-025 Comparisons use the box state registered at the same edge; outputs bullet_* and bullet_active are direct register outputs.

Reset
REQ-026 While rst=1 at a clock edge: bullet_active=0, pending=0, all box outputs=0, pixel all zeros; rst overrides fire and fsync.
REQ-027 Reset mid-flight SHALL abort the bullet; a fire held through reset deassertion is sampled from the first non-reset cycle.

Verification
REQ-028 Reset, player_x=100, fire 2 cycles, one fsync -> active=1, left=130, right=133, top=688, bottom=703.
REQ-029 Continue fsync pulses -> top 680, 672, ... 0 after 86 moves; next fsync -> active=0, top stays 0.
REQ-030 player_x=1260, fire, fsync -> left=1276, right=1279 (clamped); player_x=20 after bullet dies, fire, fsync -> left=50.
REQ-031 Fire pulsed while active -> no new bullet after current dies until a fresh fire.
REQ-032 Active bullet at left=130, top=688: hpos=131,vpos=690 -> pixel=FF,FF,FF next cycle; hpos=134 -> pixel 0.
REQ-033 Assert rst mid-flight -> next cycle active=0, box=0, pixel=0.
